softex_max_tracker: RTL and testbench
=====================================

# softex_max_tracker

Row-wise running-maximum stage placed directly upstream of the softmax accumulator. It accepts vectors of input scores, reduces each vector to its maximum, and compares that maximum with the running maximum of the current row. It forwards each vector with the running max and the previous max, so the downstream exponent/accumulator path can compute exp(x − max) and the rescaling factor exp(old_max − new_max) fed to the accumulator's `mul_i`. No floating-point arithmetic is performed, only ordered comparison.

## Interface
- `FPFORMAT`, `FPFORMAT_IN`: score format; `WIDTH = fpnew_pkg::fp_width(FPFORMAT)`.
- `N_LANES`, 16: lanes per vector.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `clear_i` in 1: synchronous flush of all state.
- `valid_i` in 1: input vector valid.
- `ready_o` out 1: input accepted when `valid_i & ready_o`.
- `data_i` in N_LANES*WIDTH: scores, lane 0 in LSBs.
- `strb_i` in N_LANES: lane-enable; disabled lanes are ignored.
- `last_i` in 1: final vector of the row.
- `valid_o` out 1: output valid.
- `ready_i` in 1: downstream ready.
- `data_o`, `strb_o`, `last_o`: the input fields, delayed.
- `max_o` out WIDTH: running row max including this vector.
- `old_max_o` out WIDTH: running row max before this vector.
- `max_upd_o` out 1: `max_o` is strictly greater than `old_max_o`.
- `nan_o` out 1: sticky flag, set when an enabled lane was NaN.

## Operation
- Ordering key: canonicalise −0 to +0, then `key = sign ? ~x : x | MSB`. A larger unsigned key means a larger value.
- NaN lanes (exp all-ones, mantissa ≠ 0) are excluded from the reduction and set `nan_o`. `nan_o` clears only on reset or `clear_i`.
- Stage 1 (registered) holds the reduction-tree max over enabled, non-NaN lanes. It is −inf if none qualify.
  - −inf is sign = 1, exponent all-ones, mantissa = 0; for BF16 that is 0xFF80.
- Stage 2 (registered) holds the vector and the stage-1 max. It combinationally computes:
  - `old_max_o = run_max`.
  - `max_o = max(run_max, vec_max)`.
  - `max_upd_o = key(vec_max) > key(run_max)`. Equal values give 0.
- `run_max` commits on the output handshake.
  - It is loaded with `max_o`, or with −inf if `last_o` is set (row restart).
  - Reset and clear value is −inf.
- An all-disabled or all-NaN vector is still forwarded: `max_o = old_max_o`, `max_upd_o = 0`.
- `clear_i` has priority over every handshake in the same cycle:
  - drops both stage valids;
  - sets `run_max` to −inf;
  - clears `nan_o`;
  - forces `ready_o = 0` for that cycle.

## Timing
- Reset values: `valid_o = 0`, `ready_o = 1`, `nan_o = 0`, `max_o = old_max_o = −inf`, `max_upd_o = 0`, data outputs 0.
- Latency is 2 cycles from input handshake to `valid_o`. Throughput is 1 vector/cycle when `ready_i = 1`.
- `ready_o = !s1_valid | !s2_valid | ready_i`, i.e. each stage advances when its downstream is free. There is no combinational valid → ready path from `valid_i` to `ready_o`.
- `valid_o` and all outputs stay stable until `ready_i` is sampled high. This is AXI-stream-like: no valid retraction.
- Back-to-back rows: the first vector of row N+1 may sit in stage 1 while the `last` vector of row N completes. Stage 2 compares against −inf, because `run_max` resets in the same edge that transfers the vector into stage 2.
- Reset mid-operation clears everything immediately; in-flight vectors are lost.

## Structure
- Shared package `softex_pkg` holds:
  - the `fp_ord_key` function;
  - `max_tracker_flags_t` (`nan`, `max_upd`).
- Sub-module `softex_max_tree`: combinational N_LANES-input ordered-max reduction with strobe and NaN masking. It outputs the max and an any-NaN flag.
- The top module holds the two pipeline registers, the `run_max` register and the handshake logic.

## Test plan
All values are BF16.
- **Single row:** with `strb` all-ones, send:
  - vec A = all 0x3F80 (1.0), then
  - vec B with lane 3 = 0x4040 (3.0), others 0x3F80, with `last`.
  
  Required response:
  - A → `old_max_o` = 0xFF80, `max_o` = 0x3F80, `max_upd_o` = 1.
  - B → `old_max_o` = 0x3F80, `max_o` = 0x4040, `max_upd_o` = 1.
  - Then `run_max` = 0xFF80.
- **Equal and smaller:** the row max is 2.0 (0x4000); send vectors of max 0x4000, then max 0xBF80 → `max_upd_o` = 0 both times, `max_o` = 0x4000.
- **Signed zero and NaN:**
  - Lanes {0x8000, 0x0000} after a row max of 0x8000 → `max_upd_o` = 0.
  - Lane 0x7FC0 with the other lanes 0x3F80 → `max_o` = 0x3F80, and `nan_o` stays 1 until `clear_i`.
- **Strobe:** `strb_i` = 0x0001 with lane 0 = 0xBF80 and the other lanes 0x7F7F → `max_o` = 0xBF80. With `strb_i` = 0 → `max_o` = `old_max_o`.
- **Backpressure:** hold `ready_i` = 0 for 5 cycles with 3 vectors offered.
  - Exactly 2 are accepted, and `ready_o` drops.
  - Outputs stay stable.
  - After release, 3 outputs appear in order with correct running max.
- **Clear and reset mid-row:** assert `clear_i` with both stages full → next cycle `valid_o` = 0 and `old_max_o` of the next vector = 0xFF80. Repeat with `rst_ni` pulsed low asynchronously → same result.

Source files
------------

// File: rtl/softex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : softex_pkg
// Description : BF16 score format, ordering-key helpers and tracker flags.
// Revision    : 1.0
// ============================================================================
package softex_pkg;

   localparam int unsigned c_EXP_BITS = 8;
   localparam int unsigned c_MAN_BITS = 7;
   localparam int unsigned c_FP_WIDTH = 1 + c_EXP_BITS + c_MAN_BITS;

   typedef logic [c_FP_WIDTH-1:0] fp_t;

   localparam fp_t c_SIGN_MSB = {1'b1, {(c_FP_WIDTH-1){1'b0}}};
   localparam fp_t c_NEG_INF  = {1'b1, {c_EXP_BITS{1'b1}}, {c_MAN_BITS{1'b0}}};

   typedef struct packed {
      logic nan;
      logic max_upd;
   } max_tracker_flags_t;

   // Monotonic unsigned key: -0 folds onto +0 so signed zeros compare equal.
   function automatic fp_t fp_ord_key(input fp_t x);
      fp_t v;
      v = (x == c_SIGN_MSB) ? '0 : x;
      return v[c_FP_WIDTH-1] ? ~v : (v | c_SIGN_MSB);
   endfunction

   function automatic logic fp_is_nan(input fp_t x);
      return (&x[c_FP_WIDTH-2 -: c_EXP_BITS]) && (|x[c_MAN_BITS-1:0]);
   endfunction

endpackage
`default_nettype wire

// File: rtl/softex_max_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : softex_max_tracker_if
// Description : Input/output vector stream of the running-max tracker.
// Revision    : 1.0
// ============================================================================
interface softex_max_tracker_if
   import softex_pkg::*;
#(
   parameter int unsigned N_LANES = 16
);

   localparam int unsigned WIDTH = c_FP_WIDTH;

   logic                     valid_i;
   logic                     ready_o;
   logic [N_LANES*WIDTH-1:0] data_i;
   logic [N_LANES-1:0]       strb_i;
   logic                     last_i;

   logic                     valid_o;
   logic                     ready_i;
   logic [N_LANES*WIDTH-1:0] data_o;
   logic [N_LANES-1:0]       strb_o;
   logic                     last_o;
   logic [WIDTH-1:0]         max_o;
   logic [WIDTH-1:0]         old_max_o;
   logic                     max_upd_o;
   logic                     nan_o;

   modport master (
      output valid_i, data_i, strb_i, last_i, ready_i,
      input  ready_o, valid_o, data_o, strb_o, last_o,
             max_o, old_max_o, max_upd_o, nan_o
   );

   modport slave (
      input  valid_i, data_i, strb_i, last_i, ready_i,
      output ready_o, valid_o, data_o, strb_o, last_o,
             max_o, old_max_o, max_upd_o, nan_o
   );

endinterface
`default_nettype wire

// File: rtl/softex_max_tree.sv
`default_nettype none
// ============================================================================
// Module      : softex_max_tree
// Description : Combinational ordered-max reduction with strobe/NaN masking.
// Revision    : 1.0
// ============================================================================
module softex_max_tree
   import softex_pkg::*;
#(
   parameter int unsigned N_LANES = 16
)(
   input  logic [N_LANES*c_FP_WIDTH-1:0] data_i,
   input  logic [N_LANES-1:0]            strb_i,
   output fp_t                           max_o,
   output logic                          nan_o
);

   localparam int N_PAD = (N_LANES < 2) ? 2 : (1 << $clog2(N_LANES));

   // Heap-ordered binary tree: leaves at [N_PAD-1 +: N_PAD], root at 0.
   fp_t  w_node [0:2*N_PAD-2];
   fp_t  w_lane;
   logic w_nan;

   always_comb begin
      w_nan  = 1'b0;
      w_lane = '0;
      for (int i = 0; i < 2*N_PAD-1; i++) begin
         w_node[i] = c_NEG_INF;
      end
      for (int i = 0; i < int'(N_LANES); i++) begin
         w_lane = data_i[i*c_FP_WIDTH +: c_FP_WIDTH];
         if (strb_i[i]) begin
            if (fp_is_nan(w_lane)) begin
               w_nan = 1'b1;
            end else begin
               w_node[N_PAD-1+i] = w_lane;
            end
         end
      end
      // Ties keep the left child, so the lowest lane wins among equals.
      for (int i = N_PAD-2; i >= 0; i--) begin
         w_node[i] = (fp_ord_key(w_node[2*i+2]) > fp_ord_key(w_node[2*i+1]))
                     ? w_node[2*i+2] : w_node[2*i+1];
      end
   end

   assign max_o = w_node[0];
   assign nan_o = w_nan;

endmodule
`default_nettype wire

// File: rtl/softex_max_tracker.sv
`default_nettype none
// ============================================================================
// Module      : softex_max_tracker
// Description : Two-stage row-wise running-max tracker ahead of softmax accum.
// Revision    : 1.0
// ============================================================================
module softex_max_tracker
   import softex_pkg::*;
#(
   parameter int unsigned N_LANES = 16
)(
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clear_i,
   softex_max_tracker_if.slave        bus
);

   localparam int unsigned WIDTH = c_FP_WIDTH;

   fp_t                      w_tree_max;
   logic                     w_tree_nan;

   logic                     r_s1_valid;
   logic [N_LANES*WIDTH-1:0] r_s1_data;
   logic [N_LANES-1:0]       r_s1_strb;
   logic                     r_s1_last;
   fp_t                      r_s1_max;

   logic                     r_s2_valid;
   logic [N_LANES*WIDTH-1:0] r_s2_data;
   logic [N_LANES-1:0]       r_s2_strb;
   logic                     r_s2_last;
   fp_t                      r_s2_max;

   fp_t                      r_run_max;
   logic                     r_nan;

   logic                     w_s1_ready;
   logic                     w_s2_ready;
   logic                     w_in_ready;
   logic                     w_in_hs;
   logic                     w_out_hs;
   logic                     w_upd;
   fp_t                      w_max;
   max_tracker_flags_t       w_flags;

   softex_max_tree #(
      .N_LANES (N_LANES)
   ) u_tree (
      .data_i  (bus.data_i),
      .strb_i  (bus.strb_i),
      .max_o   (w_tree_max),
      .nan_o   (w_tree_nan)
   );

   assign w_s2_ready = !r_s2_valid || bus.ready_i;
   assign w_s1_ready = !r_s1_valid || w_s2_ready;
   assign w_in_ready = w_s1_ready && !clear_i;
   assign w_in_hs    = bus.valid_i && w_in_ready;
   assign w_out_hs   = r_s2_valid && bus.ready_i;

   assign w_upd   = fp_ord_key(r_s2_max) > fp_ord_key(r_run_max);
   assign w_max   = w_upd ? r_s2_max : r_run_max;
   assign w_flags = '{nan: r_nan, max_upd: w_upd};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_strb  <= '0;
         r_s1_last  <= 1'b0;
         r_s1_max   <= c_NEG_INF;
      end else if (clear_i) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_strb  <= '0;
         r_s1_last  <= 1'b0;
         r_s1_max   <= c_NEG_INF;
      end else if (w_s1_ready) begin
         r_s1_valid <= bus.valid_i;
         if (bus.valid_i) begin
            r_s1_data <= bus.data_i;
            r_s1_strb <= bus.strb_i;
            r_s1_last <= bus.last_i;
            r_s1_max  <= w_tree_max;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_strb  <= '0;
         r_s2_last  <= 1'b0;
         r_s2_max   <= c_NEG_INF;
      end else if (clear_i) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_strb  <= '0;
         r_s2_last  <= 1'b0;
         r_s2_max   <= c_NEG_INF;
      end else if (w_s2_ready) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
            r_s2_strb <= r_s1_strb;
            r_s2_last <= r_s1_last;
            r_s2_max  <= r_s1_max;
         end
      end
   end

   // The row max restarts on the same edge that hands the next row's first vector to stage 2.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_run_max <= c_NEG_INF;
         r_nan     <= 1'b0;
      end else if (clear_i) begin
         r_run_max <= c_NEG_INF;
         r_nan     <= 1'b0;
      end else begin
         if (w_out_hs) begin
            r_run_max <= r_s2_last ? c_NEG_INF : w_max;
         end
         if (w_in_hs && w_tree_nan) begin
            r_nan <= 1'b1;
         end
      end
   end

   assign bus.ready_o   = w_in_ready;
   assign bus.valid_o   = r_s2_valid;
   assign bus.data_o    = r_s2_data;
   assign bus.strb_o    = r_s2_strb;
   assign bus.last_o    = r_s2_last;
   assign bus.max_o     = w_max;
   assign bus.old_max_o = r_run_max;
   assign bus.max_upd_o = w_flags.max_upd;
   assign bus.nan_o     = w_flags.nan;

endmodule
`default_nettype wire

// File: tb/tb_softex_max_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_softex_max_tracker
// Description : Directed + random bench with a real-valued running-max model.
// Revision    : 1.0
// ============================================================================
module tb_softex_max_tracker;

   localparam int NL = 16;
   localparam logic [15:0] NINF = 16'hFF80;

   typedef struct {
      logic [15:0]  old_max;
      logic [15:0]  max;
      logic         upd;
      logic [255:0] data;
      logic [15:0]  strb;
      logic         last;
   } exp_t;

   typedef struct {
      logic [15:0] old_max;
      logic [15:0] max;
      logic        upd;
   } obs_t;

   logic clk;
   logic rst_ni;
   logic clear_i;

   softex_max_tracker_if #(.N_LANES(NL)) bus ();

   softex_max_tracker #(.N_LANES(NL)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_checks = 0;
   int          n_pass   = 0;
   exp_t        exp_q[$];
   obs_t        obs_q[$];
   logic [15:0] model_run = NINF;
   logic        model_nan = 1'b0;
   logic        acc;
   logic        rand_ready = 1'b0;

   logic [255:0] va, vb, vc;
   logic [255:0] bp [3];
   int           n_acc, idx;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] want);
      n_checks++;
      assert (obs === want) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
   endtask

   function automatic real bf_val(input logic [15:0] b);
      real r, m;
      int  e;
      e = int'(b[14:7]);
      m = b[6:0];
      if (e == 255)    r = 1.0e300;
      else if (e == 0) r = (m / 128.0) * (2.0 ** (-126));
      else             r = (1.0 + m / 128.0) * (2.0 ** (e - 127));
      return b[15] ? -r : r;
   endfunction

   function automatic logic is_nan(input logic [15:0] b);
      return (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
   endfunction

   task automatic model_accept(input logic [255:0] d, input logic [15:0] s, input logic l);
      exp_t        e;
      logic [15:0] vm, lane;
      logic        found;
      found = 1'b0;
      vm    = NINF;
      for (int i = 0; i < NL; i++) begin
         lane = d[i*16 +: 16];
         if (s[i]) begin
            if (is_nan(lane)) model_nan = 1'b1;
            else if (!found || bf_val(lane) > bf_val(vm)) begin
               vm    = lane;
               found = 1'b1;
            end
         end
      end
      e.old_max = model_run;
      if (found && bf_val(vm) > bf_val(model_run)) begin
         e.max = vm;
         e.upd = 1'b1;
      end else begin
         e.max = model_run;
         e.upd = 1'b0;
      end
      e.data = d;
      e.strb = s;
      e.last = l;
      model_run = l ? NINF : e.max;
      exp_q.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      obs_t o;
      @(negedge clk);
      acc = bus.valid_i && bus.ready_o;
      if (bus.valid_o && bus.ready_i) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("data_o", bus.data_o, e.data);
            check("strb_o", bus.strb_o, e.strb);
            check("last_o", bus.last_o, e.last);
            check("old_max_o", bus.old_max_o, e.old_max);
            check("max_o", bus.max_o, e.max);
            check("max_upd_o", bus.max_upd_o, e.upd);
            o.old_max = bus.old_max_o;
            o.max     = bus.max_o;
            o.upd     = bus.max_upd_o;
            obs_q.push_back(o);
         end
      end
      if (acc) model_accept(bus.data_i, bus.strb_i, bus.last_i);
      @(posedge clk);
      #1;
      if (rand_ready) bus.ready_i = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [255:0] d, input logic [15:0] s, input logic l);
      logic done;
      done = 1'b0;
      bus.valid_i = 1'b1;
      bus.data_i  = d;
      bus.strb_i  = s;
      bus.last_i  = l;
      for (int k = 0; k < 100; k++) begin
         step();
         if (acc) begin
            done = 1'b1;
            break;
         end
      end
      check("accept_timeout", done, 1);
      bus.valid_i = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200; k++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      check("drain_timeout", exp_q.size(), 0);
   endtask

   function automatic logic [15:0] rand_lane();
      logic [15:0] v;
      case ($urandom_range(0, 11))
         0:       v = 16'h7FC0;
         1:       v = 16'h8000;
         2:       v = 16'h0000;
         3:       v = 16'h7F80;
         4:       v = 16'hFF80;
         5:       v = 16'hFFC1;
         default: v = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 7'($urandom_range(0, 127))};
      endcase
      return v;
   endfunction

   function automatic logic [255:0] rand_vec();
      logic [255:0] d;
      for (int i = 0; i < NL; i++) d[i*16 +: 16] = rand_lane();
      return d;
   endfunction

   function automatic logic [255:0] fill(input logic [15:0] v);
      logic [255:0] d;
      for (int i = 0; i < NL; i++) d[i*16 +: 16] = v;
      return d;
   endfunction

   initial begin
      bus.valid_i = 1'b0;
      bus.data_i  = '0;
      bus.strb_i  = '0;
      bus.last_i  = 1'b0;
      bus.ready_i = 1'b1;
      clear_i     = 1'b0;
      rst_ni      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_ni = 1'b1;

      // Reset state
      check("rst_valid_o", bus.valid_o, 0);
      check("rst_ready_o", bus.ready_o, 1);
      check("rst_nan_o", bus.nan_o, 0);
      check("rst_max_o", bus.max_o, NINF);
      check("rst_old_max_o", bus.old_max_o, NINF);
      check("rst_max_upd_o", bus.max_upd_o, 0);
      check("rst_data_o", bus.data_o, 0);

      // Single row
      obs_q.delete();
      va = fill(16'h3F80);
      vb = va;
      vb[3*16 +: 16] = 16'h4040;
      send(va, 16'hFFFF, 1'b0);
      send(vb, 16'hFFFF, 1'b1);
      drain();
      check("row_count", obs_q.size(), 2);
      check("rowA_old", obs_q[0].old_max, 16'hFF80);
      check("rowA_max", obs_q[0].max, 16'h3F80);
      check("rowA_upd", obs_q[0].upd, 1);
      check("rowB_old", obs_q[1].old_max, 16'h3F80);
      check("rowB_max", obs_q[1].max, 16'h4040);
      check("rowB_upd", obs_q[1].upd, 1);
      check("row_restart", bus.old_max_o, 16'hFF80);

      // Equal and smaller than the row max
      obs_q.delete();
      va = fill(16'h3F80);
      va[$urandom_range(0, 15)*16 +: 16] = 16'h4000;
      vb = '0;
      for (int i = 0; i < NL; i++) vb[i*16 +: 16] = ($urandom_range(0, 1) != 0) ? 16'h3F00 : 16'h3F80;
      vb[$urandom_range(0, 15)*16 +: 16] = 16'h4000;
      vc = fill(16'hC000);
      vc[$urandom_range(0, 15)*16 +: 16] = 16'hBF80;
      send(va, 16'hFFFF, 1'b0);
      send(vb, 16'hFFFF, 1'b0);
      send(vc, 16'hFFFF, 1'b1);
      drain();
      check("equal_upd", obs_q[1].upd, 0);
      check("equal_max", obs_q[1].max, 16'h4000);
      check("smaller_upd", obs_q[2].upd, 0);
      check("smaller_max", obs_q[2].max, 16'h4000);

      // Signed zero and NaN
      obs_q.delete();
      va = fill(16'h1234);
      va[15:0] = 16'h8000;
      vb = fill(16'h1234);
      vb[15:0]  = 16'h8000;
      vb[31:16] = 16'h0000;
      vc = fill(16'h3F80);
      vc[15:0] = 16'h7FC0;
      send(va, 16'h0001, 1'b0);
      send(vb, 16'h0003, 1'b0);
      send(vc, 16'hFFFF, 1'b0);
      drain();
      check("zero_upd", obs_q[1].upd, 0);
      check("nan_max", obs_q[2].max, 16'h3F80);
      check("nan_set", bus.nan_o, 1);
      send(fill(16'h3F80), 16'hFFFF, 1'b0);
      send(fill(16'h3F00), 16'hFFFF, 1'b1);
      drain();
      check("nan_sticky", bus.nan_o, 1);

      // Strobe masking
      obs_q.delete();
      va = fill(16'h7F7F);
      va[15:0] = 16'hBF80;
      send(va, 16'h0001, 1'b0);
      send(rand_vec(), 16'h0000, 1'b1);
      drain();
      check("strb_one_max", obs_q[0].max, 16'hBF80);
      check("strb_zero_max", obs_q[1].max, 16'hBF80);
      check("strb_zero_old", obs_q[1].old_max, 16'hBF80);
      check("strb_zero_upd", obs_q[1].upd, 0);
      check("nan_before_clear", bus.nan_o, 1);
      clear_i = 1'b1;
      step();
      clear_i   = 1'b0;
      model_nan = 1'b0;
      model_run = NINF;
      check("nan_cleared", bus.nan_o, 0);

      // Random vectors with random downstream stalls
      rand_ready = 1'b1;
      for (int n = 0; n < 60; n++) begin
         logic [15:0] s;
         case ($urandom_range(0, 3))
            0:       s = 16'h0000;
            1:       s = 16'($urandom);
            default: s = 16'hFFFF;
         endcase
         send(rand_vec(), s, ($urandom_range(0, 3) == 0));
      end
      drain();
      rand_ready  = 1'b0;
      bus.ready_i = 1'b1;
      check("rand_nan", bus.nan_o, model_nan);

      // Backpressure: two accepted, outputs held while stalled
      obs_q.delete();
      for (int i = 0; i < 3; i++) bp[i] = rand_vec();
      bus.ready_i = 1'b0;
      idx   = 0;
      n_acc = 0;
      bus.valid_i = 1'b1;
      bus.data_i  = bp[0];
      bus.strb_i  = 16'hFFFF;
      bus.last_i  = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (acc) begin
            n_acc++;
            idx++;
            bus.data_i = bp[idx];
            bus.last_i = (idx == 2);
         end
         if (c >= 1) begin
            check("bp_valid_o", bus.valid_o, 1);
            check("bp_hold_data", bus.data_o, exp_q[0].data);
            check("bp_hold_max", bus.max_o, exp_q[0].max);
         end
      end
      check("bp_accepted", n_acc, 2);
      check("bp_ready_o", bus.ready_o, 0);
      bus.ready_i = 1'b1;
      send(bp[2], 16'hFFFF, 1'b1);
      drain();
      check("bp_out_count", obs_q.size(), 3);

      // Clear with both stages full
      send(fill(16'h3F80), 16'hFFFF, 1'b0);
      drain();
      bus.ready_i = 1'b0;
      send(fill(16'h4000), 16'hFFFF, 1'b0);
      send(fill(16'h4040), 16'hFFFF, 1'b0);
      clear_i = 1'b1;
      #1;
      check("clr_ready_o", bus.ready_o, 0);
      step();
      clear_i = 1'b0;
      check("clr_valid_o", bus.valid_o, 0);
      exp_q.delete();
      model_run = NINF;
      model_nan = 1'b0;
      bus.ready_i = 1'b1;
      obs_q.delete();
      send(fill(16'h3F00), 16'hFFFF, 1'b0);
      drain();
      check("clr_next_old", obs_q[0].old_max, 16'hFF80);

      // Asynchronous reset with both stages full
      bus.ready_i = 1'b0;
      send(fill(16'h4000), 16'hFFFF, 1'b0);
      send(fill(16'h4040), 16'hFFFF, 1'b0);
      #3;
      rst_ni = 1'b0;
      #1;
      check("arst_valid_o", bus.valid_o, 0);
      check("arst_ready_o", bus.ready_o, 1);
      check("arst_old_max", bus.old_max_o, NINF);
      @(posedge clk);
      #2;
      rst_ni = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      model_run = NINF;
      model_nan = 1'b0;
      bus.ready_i = 1'b1;
      obs_q.delete();
      send(fill(16'h3F80), 16'hFFFF, 1'b1);
      drain();
      check("arst_next_old", obs_q[0].old_max, 16'hFF80);
      check("arst_next_upd", obs_q[0].upd, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
